// File: rtl/fft_ram_pkg.sv
// Shared types and size helpers for the FFT ping-pong sample memory.
package fft_ram_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    // Words per bank.
    function automatic int unsigned fft_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

    // Physical address width: bank select bit plus per-bank address.
    function automatic int unsigned fft_phys_aw(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port RAM, one clock, registered read; array has no reset so it maps to block RAM.
module sdp_bram #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PHYS_AW = 9
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               we,
    input  logic [PHYS_AW-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               re,
    input  logic [PHYS_AW-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [0:(1 << PHYS_AW)-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; it holds its value between reads.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_pingpong_ram.sv
// Dual-bank ping-pong sample buffer: sequential writer fills one bank while the FFT reads the other.
module fft_pingpong_ram
    import fft_ram_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_bank_full,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_release
);

    localparam int unsigned        PHYS_AW     = fft_phys_aw(ADDR_W);
    localparam int unsigned        DEPTH       = fft_depth(ADDR_W);
    localparam logic [ADDR_W-1:0]  WCNT_LAST   = ADDR_W'(DEPTH - 1);
    localparam state_t             RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

    state_t             state, state_nxt;
    logic [PHYS_AW-1:0] clr_cnt, clr_cnt_nxt;
    logic [1:0]         full, full_nxt;
    logic               wb, wb_nxt;
    logic               rb, rb_nxt;
    logic [ADDR_W-1:0]  wcnt, wcnt_nxt;

    logic               wr_acc_c;
    logic               rd_fire_c;
    logic               rel_c;
    logic               mem_we_c;
    logic [PHYS_AW-1:0] mem_waddr_c;
    logic [DATA_W-1:0]  mem_wdata_c;

    // Next-state, bank bookkeeping and clear/write mux for the RAM write port.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        full_nxt    = full;
        wb_nxt      = wb;
        rb_nxt      = rb;
        wcnt_nxt    = wcnt;
        wr_acc_c    = wr_valid && wr_ready;
        rd_fire_c   = rd_en && full[rb];
        rel_c       = rd_release && full[rb];
        mem_we_c    = 1'b0;
        mem_waddr_c = {wb, wcnt};
        mem_wdata_c = wr_data;

        case (state)
            S_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_cnt;
                mem_wdata_c = '0;
                clr_cnt_nxt = clr_cnt + PHYS_AW'(1);
                if (&clr_cnt) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (wr_acc_c) begin
                    mem_we_c = 1'b1;
                    wcnt_nxt = wcnt + ADDR_W'(1);
                    if (wcnt == WCNT_LAST) begin
                        full_nxt[wb] = 1'b1;
                        wb_nxt       = ~wb;
                    end
                end
                // A finishing write and a release never target the same bank.
                if (rel_c) begin
                    full_nxt[rb] = 1'b0;
                    rb_nxt       = ~rb;
                end
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // State, pointers and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= RESET_STATE;
            clr_cnt      <= '0;
            full         <= '0;
            wb           <= 1'b0;
            rb           <= 1'b0;
            wcnt         <= '0;
            busy         <= 1'b1;
            wr_ready     <= 1'b0;
            rd_bank_full <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            state        <= state_nxt;
            clr_cnt      <= clr_cnt_nxt;
            full         <= full_nxt;
            wb           <= wb_nxt;
            rb           <= rb_nxt;
            wcnt         <= wcnt_nxt;
            busy         <= (state_nxt == S_CLEAR);
            wr_ready     <= (state_nxt == S_RUN) && !full_nxt[wb_nxt];
            rd_bank_full <= full_nxt[rb_nxt];
            rd_valid     <= rd_fire_c;
        end
    end

    sdp_bram #(
        .DATA_W  (DATA_W),
        .PHYS_AW (PHYS_AW)
    ) u_ram (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (mem_we_c),
        .waddr (mem_waddr_c),
        .wdata (mem_wdata_c),
        .re    (rd_fire_c),
        .raddr ({rb, rd_addr}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Randomized bench for fft_pingpong_ram against a frame-level ping-pong reference model.
module tb_fft_pingpong_ram;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int WORDS  = 512;

    logic              CLK;
    logic              RST_N;
    logic              busy;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_bank_full;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_release;

    fft_pingpong_ram #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .busy         (busy),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_bank_full (rd_bank_full),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_release   (rd_release)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: memory image, bank flags and pointers.
    logic [DATA_W-1:0] m_mem [WORDS];
    bit                m_full [2];
    int                m_wb, m_rb, m_wcnt;
    logic [DATA_W-1:0] m_rd_data;
    bit                m_rd_valid;
    bit                m_run;

    function automatic bit exp_ready();
        return m_run && !m_full[m_wb];
    endfunction

    function automatic bit exp_full();
        return m_full[m_rb];
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input bit wv, input logic [DATA_W-1:0] wd, input bit re,
                       input logic [ADDR_W-1:0] ra, input bit rel);
        bit acc, rdf, relf;
        wr_valid   = wv;
        wr_data    = wd;
        rd_en      = re;
        rd_addr    = ra;
        rd_release = rel;
        acc  = wv && exp_ready();
        rdf  = re && m_full[m_rb];
        relf = rel && m_full[m_rb];
        m_rd_valid = rdf;
        if (rdf) m_rd_data = m_mem[m_rb * DEPTH + int'(ra)];
        if (acc) begin
            m_mem[m_wb * DEPTH + m_wcnt] = wd;
            m_wcnt++;
            if (m_wcnt == DEPTH) begin
                m_wcnt         = 0;
                m_full[m_wb]   = 1'b1;
                m_wb           = 1 - m_wb;
            end
        end
        if (relf) begin
            m_full[m_rb] = 1'b0;
            m_rb         = 1 - m_rb;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic write_rand(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset(input bit chk_mem);
        int cnt;
        RST_N = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (busy !== 1'b1)         begin bad++; $display("FAIL rst_busy: got %b expected 1", busy); end
        total++; if (wr_ready !== 1'b0)     begin bad++; $display("FAIL rst_wr_ready: got %b expected 0", wr_ready); end
        total++; if (rd_bank_full !== 1'b0) begin bad++; $display("FAIL rst_rd_bank_full: got %b expected 0", rd_bank_full); end
        total++; if (rd_data !== '0)        begin bad++; $display("FAIL rst_rd_data: got %h expected 0000", rd_data); end
        total++; if (rd_valid !== 1'b0)     begin bad++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        m_full[0] = 0; m_full[1] = 0; m_wb = 0; m_rb = 0; m_wcnt = 0;
        m_rd_data = '0; m_rd_valid = 0; m_run = 0;
        RST_N = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            @(posedge CLK);
            #1;
        end
        total++; if (cnt != WORDS)       begin bad++; $display("FAIL sweep_len: got %0d cycles expected %0d", cnt, WORDS); end
        total++; if (wr_ready !== 1'b1)  begin bad++; $display("FAIL sweep_wr_ready: got %b expected 1", wr_ready); end
        m_run = 1;
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        if (chk_mem) begin
            for (int i = 0; i < WORDS; i++) begin
                total++;
                if (dut.u_ram.mem[i] !== 16'h0000) begin
                    bad++; $display("FAIL sweep_zero[%0d]: got %h expected 0000", i, dut.u_ram.mem[i]);
                end
            end
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL sf_ready[%0d]: got %b expected 1", i, wr_ready); end
            total++; if (rd_bank_full !== 1'b0) begin bad++; $display("FAIL sf_early_full[%0d]: got %b expected 0", i, rd_bank_full); end
            cyc(1'b1, DATA_W'(i), 1'b0, '0, 1'b0);
        end
        total++; if (rd_bank_full !== 1'b1) begin bad++; $display("FAIL sf_full: got %b expected 1", rd_bank_full); end
        total++; if (wr_ready !== 1'b1)     begin bad++; $display("FAIL sf_ready_b1: got %b expected 1", wr_ready); end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            cyc(1'b0, '0, 1'b1, ADDR_W'(a), 1'b0);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== DATA_W'(a)) begin
                bad++; $display("FAIL sf_read[%0d]: got v=%b d=%h expected v=1 d=%h", a, rd_valid, rd_data, DATA_W'(a));
            end
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b0);
        total++; if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            bad++; $display("FAIL sf_idle: got v=%b d=%h expected v=0 d=0000", rd_valid, rd_data);
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        total++; if (rd_bank_full !== 1'b0) begin bad++; $display("FAIL sf_release: got %b expected 0", rd_bank_full); end
    endtask

    task automatic test_pingpong_stall();
        logic [DATA_W-1:0] held;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL pp_ready[%0d]: got %b expected 1", i, wr_ready); end
            cyc(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b0);
        end
        total++; if (wr_ready !== 1'b0)     begin bad++; $display("FAIL pp_stall: got %b expected 0", wr_ready); end
        total++; if (rd_bank_full !== 1'b1) begin bad++; $display("FAIL pp_full: got %b expected 1", rd_bank_full); end
        held = DATA_W'($urandom);
        repeat (4) begin
            cyc(1'b1, held, 1'b0, '0, 1'b0);
            total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL pp_hold: got %b expected 0", wr_ready); end
        end
        cyc(1'b1, held, 1'b0, '0, 1'b1);
        total++; if (wr_ready !== 1'b1)     begin bad++; $display("FAIL pp_rel_ready: got %b expected 1", wr_ready); end
        total++; if (rd_bank_full !== 1'b1) begin bad++; $display("FAIL pp_rel_full: got %b expected 1", rd_bank_full); end
        for (int i = 0; i < 32; i++) begin
            a = ADDR_W'($urandom);
            if (i == 0) cyc(1'b1, held, 1'b1, a, 1'b0);
            else        cyc(1'b0, '0, 1'b1, a, 1'b0);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                bad++; $display("FAIL pp_read_b0[%0h]: got v=%b d=%h expected v=1 d=%h", a, rd_valid, rd_data, m_rd_data);
            end
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        write_rand(DEPTH - 1);
        total++; if (rd_bank_full !== exp_full()) begin bad++; $display("FAIL pp_b1_full: got %b expected %b", rd_bank_full, exp_full()); end
        cyc(1'b0, '0, 1'b1, '0, 1'b0);
        total++; if (rd_valid !== 1'b1 || rd_data !== held) begin
            bad++; $display("FAIL pp_held_word: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, held);
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        total++; if (rd_bank_full !== 1'b0 || wr_ready !== 1'b1) begin
            bad++; $display("FAIL pp_drained: got full=%b ready=%b expected full=0 ready=1", rd_bank_full, wr_ready);
        end
    endtask

    task automatic test_simultaneous();
        logic [ADDR_W-1:0] a;
        write_rand(2 * DEPTH - 1);
        cyc(1'b1, DATA_W'($urandom), 1'b0, '0, 1'b1);
        total++; if (rd_bank_full !== 1'b1) begin bad++; $display("FAIL sim_full: got %b expected 1", rd_bank_full); end
        total++; if (wr_ready !== 1'b1)     begin bad++; $display("FAIL sim_ready: got %b expected 1", wr_ready); end
        for (int i = 0; i < 16; i++) begin
            a = (i == 0) ? ADDR_W'(DEPTH - 1) : ADDR_W'($urandom);
            cyc(1'b0, '0, 1'b1, a, 1'b0);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                bad++; $display("FAIL sim_read_b1[%0h]: got v=%b d=%h expected v=1 d=%h", a, rd_valid, rd_data, m_rd_data);
            end
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        total++; if (rd_bank_full !== 1'b0) begin bad++; $display("FAIL sim_drained: got %b expected 0", rd_bank_full); end
    endtask

    task automatic test_illegal();
        logic [DATA_W-1:0] prev;
        logic [ADDR_W-1:0] a;
        prev = m_rd_data;
        cyc(1'b0, '0, 1'b1, ADDR_W'($urandom), 1'b0);
        total++; if (rd_valid !== 1'b0 || rd_data !== prev) begin
            bad++; $display("FAIL ill_read: got v=%b d=%h expected v=0 d=%h", rd_valid, rd_data, prev);
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
        total++; if (rd_bank_full !== 1'b0 || wr_ready !== 1'b1) begin
            bad++; $display("FAIL ill_release: got full=%b ready=%b expected full=0 ready=1", rd_bank_full, wr_ready);
        end
        cyc(1'b0, '0, 1'b1, ADDR_W'($urandom), 1'b1);
        total++; if (rd_valid !== 1'b0 || rd_data !== prev || rd_bank_full !== 1'b0) begin
            bad++; $display("FAIL ill_both: got v=%b d=%h full=%b expected v=0 d=%h full=0", rd_valid, rd_data, rd_bank_full, prev);
        end
        write_rand(DEPTH);
        total++; if (rd_bank_full !== 1'b1) begin bad++; $display("FAIL ill_rb_kept: got %b expected 1", rd_bank_full); end
        for (int i = 0; i < 16; i++) begin
            a = ADDR_W'($urandom);
            cyc(1'b0, '0, 1'b1, a, 1'b0);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                bad++; $display("FAIL ill_read_back[%0h]: got v=%b d=%h expected v=1 d=%h", a, rd_valid, rd_data, m_rd_data);
            end
        end
        cyc(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        logic [ADDR_W-1:0] a;
        write_rand(100);
        test_reset(1'b1);
        write_rand(DEPTH);
        total++; if (rd_bank_full !== 1'b1) begin bad++; $display("FAIL rmf_full: got %b expected 1", rd_bank_full); end
        for (int i = 0; i < 64; i++) begin
            a = ADDR_W'($urandom);
            cyc(1'b0, '0, 1'b1, a, 1'b0);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                bad++; $display("FAIL rmf_read[%0h]: got v=%b d=%h expected v=1 d=%h", a, rd_valid, rd_data, m_rd_data);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        m_run = 0;
        test_reset(1'b1);
        test_single_frame();
        test_pingpong_stall();
        test_simultaneous();
        test_illegal();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
